// File: rtl/tx_packet_arbiter.sv
// Packet-aware fixed-priority tx arbiter with age-based promotion and one registered output stage.
// Define TX_PACKET_ARBITER_STATS_EN to add per-source grant and starvation-promotion counters.
module tx_packet_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned STARVE_LIMIT = 16,
  parameter int unsigned FLIT_W       = 32,
  localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]         flit_out,
  output logic                      flit_out_valid,
  input  logic                      flit_out_ready,
  output logic [ID_W-1:0]           grant_id
`ifdef TX_PACKET_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     stat_grants,
  output logic [31:0]               stat_starve_promotions
`endif
);

  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   lock_id, lock_id_next;
  logic [AGE_W-1:0]  age [NUM_REQ];
  logic [FLIT_W-1:0] flit_arr [NUM_REQ];
  logic [ID_W-1:0]   prio_sel, starve_sel, sel;
  logic              prio_found, starve_found, has_sel;
  logic              can_accept, transfer, promoted;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_flit
    assign flit_arr[g] = req_flit[g*FLIT_W +: FLIT_W];
  end

  // Downward scan so the lowest index is the one left standing
  always_comb begin
    prio_found   = 1'b0;
    prio_sel     = '0;
    starve_found = 1'b0;
    starve_sel   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[ID_W'(i)]) begin
        prio_found = 1'b1;
        prio_sel   = ID_W'(i);
      end
      if (req_valid[ID_W'(i)] && age[ID_W'(i)] == AGE_MAX) begin
        starve_found = 1'b1;
        starve_sel   = ID_W'(i);
      end
    end
  end

  // Next-state, selection and ready; ready is suppressed while reset is asserted
  always_comb begin
    state_next   = state;
    lock_id_next = lock_id;
    sel          = '0;
    has_sel      = 1'b0;
    promoted     = 1'b0;
    req_ready    = '0;
    can_accept   = !flit_out_valid || flit_out_ready;
    case (state)
      IDLE: begin
        if (starve_found) begin
          sel      = starve_sel;
          has_sel  = 1'b1;
          promoted = (starve_sel != prio_sel);
        end else if (prio_found) begin
          sel     = prio_sel;
          has_sel = 1'b1;
        end
      end
      LOCKED: begin
        sel     = lock_id;
        has_sel = 1'b1;
      end
      default: ;
    endcase
    if (has_sel && !rst) req_ready[sel] = can_accept;
    transfer = has_sel && can_accept && req_valid[sel] && !rst;
    if (transfer) begin
      if (state == IDLE && !req_last[sel]) begin
        state_next   = LOCKED;
        lock_id_next = sel;
      end else if (state == LOCKED && req_last[sel]) begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      lock_id        <= '0;
      flit_out       <= '0;
      flit_out_valid <= 1'b0;
      grant_id       <= '0;
    end else begin
      state   <= state_next;
      lock_id <= lock_id_next;
      if (transfer) begin
        flit_out       <= flit_arr[sel];
        grant_id       <= sel;
        flit_out_valid <= 1'b1;
      end else if (flit_out_ready) begin
        flit_out_valid <= 1'b0;
      end
    end
  end

  // Highest-priority source never needs promotion
  assign age[0] = '0;

  for (genvar g = 1; g < NUM_REQ; g++) begin : g_age
    logic [AGE_W-1:0] age_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        age_q <= '0;
      end else if (req_valid[g] && !req_ready[g]) begin
        if (age_q != AGE_MAX) age_q <= age_q + AGE_W'(1);
      end else begin
        age_q <= '0;
      end
    end
    assign age[g] = age_q;
  end

`ifdef TX_PACKET_ARBITER_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [31:0] grant_cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        grant_cnt <= '0;
      end else if (transfer && sel == ID_W'(g)) begin
        grant_cnt <= grant_cnt + 32'd1;
      end
    end
    assign stat_grants[g*32 +: 32] = grant_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_starve_promotions <= '0;
    end else if (transfer && promoted) begin
      stat_starve_promotions <= stat_starve_promotions + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Randomized and directed bench for tx_packet_arbiter against a cycle-level behavioural model.
module tb_tx_packet_arbiter;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned STARVE_LIMIT = 16;
  localparam int unsigned FLIT_W       = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ*FLIT_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_valid, req_last, req_ready;
  logic [FLIT_W-1:0]         flit_out;
  logic                      flit_out_valid, flit_out_ready;
  logic [1:0]                grant_id;
`ifdef TX_PACKET_ARBITER_STATS_EN
  logic [NUM_REQ*32-1:0]     stat_grants;
  logic [31:0]               stat_starve_promotions;
`endif

  tx_packet_arbiter #(
    .NUM_REQ(NUM_REQ), .STARVE_LIMIT(STARVE_LIMIT), .FLIT_W(FLIT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_flit(req_flit), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .flit_out(flit_out), .flit_out_valid(flit_out_valid),
    .flit_out_ready(flit_out_ready), .grant_id(grant_id)
`ifdef TX_PACKET_ARBITER_STATS_EN
    , .stat_grants(stat_grants), .stat_starve_promotions(stat_starve_promotions)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int          m_age [NUM_REQ];
  bit          m_locked;
  int          m_lock;
  bit          m_ovalid;
  logic [31:0] m_oflit;
  int          m_ogrant;
  int          m_grants [NUM_REQ];
  int          m_promos;
  logic [NUM_REQ-1:0] exp_ready, obs_ready, acc;

  task automatic m_reset();
    m_locked = 0; m_lock = 0; m_ovalid = 0; m_oflit = '0; m_ogrant = 0; m_promos = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_age[i] = 0;
      m_grants[i] = 0;
    end
  endtask

  task automatic drive(input int s, input bit v, input bit l, input logic [31:0] f);
    req_valid[s] = v;
    req_last[s]  = l;
    req_flit[s*FLIT_W +: FLIT_W] = f;
  endtask

  // One clock: predict and sample ready before the edge, advance the model at the edge
  task automatic cycle();
    int s, plain;
    bit promo;
    #1;
    s = -1; plain = -1; promo = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req_valid[i]) plain = i;
    if (m_locked) begin
      s = m_lock;
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--)
        if (req_valid[i] && m_age[i] >= int'(STARVE_LIMIT)) s = i;
      if (s >= 0) promo = (s != plain);
      else s = plain;
    end
    exp_ready = '0;
    if (s >= 0 && (!m_ovalid || flit_out_ready)) exp_ready[s] = 1'b1;
    obs_ready = req_ready;
    acc = exp_ready & req_valid;
    @(posedge clk);
    for (int i = 1; i < NUM_REQ; i++) begin
      if (req_valid[i] && !exp_ready[i])
        m_age[i] = (m_age[i] + 1 > int'(STARVE_LIMIT)) ? int'(STARVE_LIMIT) : m_age[i] + 1;
      else
        m_age[i] = 0;
    end
    if (acc != '0) begin
      m_ovalid = 1; m_oflit = req_flit[s*FLIT_W +: FLIT_W]; m_ogrant = s;
      m_grants[s]++;
      if (promo) m_promos++;
      if (!m_locked && !req_last[s]) begin
        m_locked = 1; m_lock = s;
      end else if (m_locked && req_last[s]) begin
        m_locked = 0;
      end
    end else if (flit_out_ready) begin
      m_ovalid = 0;
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; flit_out_ready = 1'b1;
    req_valid = '1; req_last = '1;
    req_flit = {32'h3, 32'h2, 32'h1, 32'h0};
    #2;
    vectors++;
    if (flit_out_valid !== 1'b0 || grant_id !== 2'd0 || flit_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b grant=%0d flit=%h, want 0/0/0", flit_out_valid, grant_id, flit_out);
    end
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; m_reset();
    // src2 three-flit packet, reset lands on the third flit
    drive(2, 1, 0, 32'h2000_0001); cycle();
    vectors++;
    if (grant_id !== 2'd2 || flit_out !== 32'h2000_0001 || flit_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pkt_flit1: got grant=%0d flit=%h valid=%0b want 2/20000001/1", grant_id, flit_out, flit_out_valid);
    end
    drive(2, 1, 0, 32'h2000_0002); cycle();
    vectors++;
    if (flit_out !== 32'h2000_0002) begin
      miscompares++;
      $display("FAIL reset_pkt_flit2: got %h want 20000002", flit_out);
    end
    drive(2, 1, 1, 32'h2000_0003);
    #2; rst = 1'b1; #1;
    vectors++;
    if (flit_out_valid !== 1'b0 || flit_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_async: got valid=%0b flit=%h want 0/0", flit_out_valid, flit_out);
    end
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_midpkt_ready: got %b want 0000", req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 4'b0000 || flit_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: got ready=%b valid=%0b want 0000/0", req_ready, flit_out_valid);
    end
    rst = 1'b0; m_reset();
    req_valid = '0;
    drive(1, 1, 1, 32'h1000_00AA); cycle();
    vectors++;
    if (grant_id !== 2'd1 || flit_out !== 32'h1000_00AA || flit_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_lock_dropped: got grant=%0d flit=%h valid=%0b want 1/100000aa/1", grant_id, flit_out, flit_out_valid);
    end
    req_valid = '0; cycle();
  endtask

  task automatic test_priority();
    flit_out_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1, 1, 32'hA0 + i);
    for (int k = 0; k < NUM_REQ; k++) begin
      cycle();
      vectors++;
      if (obs_ready !== (4'b0001 << k) || flit_out_valid !== 1'b1 || grant_id !== 2'(k) ||
          flit_out !== 32'hA0 + k) begin
        miscompares++;
        $display("FAIL priority_%0d: got ready=%b valid=%0b grant=%0d flit=%h want %b/1/%0d/%h",
                 k, obs_ready, flit_out_valid, grant_id, flit_out, 4'b0001 << k, k, 32'hA0 + k);
      end
      req_valid = req_valid & ~acc;
    end
    cycle();
    vectors++;
    if (flit_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL priority_drain: got valid=%0b want 0", flit_out_valid);
    end
  endtask

  task automatic test_lock();
    req_valid = '0; flit_out_ready = 1'b1;
    drive(3, 1, 0, 32'h30); cycle();
    drive(0, 1, 1, 32'h0A); drive(3, 1, 0, 32'h31); cycle();
    vectors++;
    if (grant_id !== 2'd3 || flit_out !== 32'h31 || obs_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL lock_flit2: got grant=%0d flit=%h ready=%b want 3/31/1000", grant_id, flit_out, obs_ready);
    end
    req_valid[3] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      cycle();
      vectors++;
      if (flit_out_valid !== 1'b0 || obs_ready[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL lock_bubble_%0d: got valid=%0b ready0=%0b want 0/0", b, flit_out_valid, obs_ready[0]);
      end
    end
    drive(3, 1, 0, 32'h32); cycle();
    drive(3, 1, 1, 32'h33); cycle();
    vectors++;
    if (grant_id !== 2'd3 || flit_out !== 32'h33) begin
      miscompares++;
      $display("FAIL lock_last: got grant=%0d flit=%h want 3/33", grant_id, flit_out);
    end
    req_valid[3] = 1'b0; cycle();
    vectors++;
    if (grant_id !== 2'd0 || flit_out !== 32'h0A || flit_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_release: got grant=%0d flit=%h want 0/0a", grant_id, flit_out);
    end
    req_valid = '0; cycle();
  endtask

  task automatic test_starvation();
    int bad;
`ifdef TX_PACKET_ARBITER_STATS_EN
    logic [31:0] promos0;
    promos0 = stat_starve_promotions;
`endif
    flit_out_ready = 1'b1;
    drive(0, 1, 1, 32'h0); drive(3, 1, 1, 32'h3F);
    bad = 0;
    for (int n = 1; n <= int'(STARVE_LIMIT); n++) begin
      cycle();
      if (grant_id !== 2'd0 || obs_ready !== 4'b0001) bad++;
      drive(0, 1, 1, 32'(n));
    end
    vectors++;
    if (bad != 0 || int'(dut.age[3]) != int'(STARVE_LIMIT)) begin
      miscompares++;
      $display("FAIL starve_wait: got %0d wrong grants, age3=%0d want 0 and %0d", bad, dut.age[3], STARVE_LIMIT);
    end
    cycle();
    vectors++;
    if (obs_ready !== 4'b1000 || grant_id !== 2'd3 || flit_out !== 32'h3F || dut.age[3] !== 5'd0) begin
      miscompares++;
      $display("FAIL starve_promote: got ready=%b grant=%0d flit=%h age3=%0d want 1000/3/3f/0",
               obs_ready, grant_id, flit_out, dut.age[3]);
    end
`ifdef TX_PACKET_ARBITER_STATS_EN
    vectors++;
    if (stat_starve_promotions - promos0 !== 32'd1) begin
      miscompares++;
      $display("FAIL starve_stat: got delta %0d want 1", stat_starve_promotions - promos0);
    end
`endif
    req_valid = '0; cycle();
  endtask

  task automatic test_backpressure();
    flit_out_ready = 1'b1;
    drive(2, 1, 1, 32'hB0); cycle();
    drive(2, 1, 1, 32'hB1); flit_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      vectors++;
      if (obs_ready !== 4'b0000 || flit_out !== 32'hB0 || flit_out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_stall_%0d: got ready=%b flit=%h valid=%0b want 0000/b0/1", c, obs_ready, flit_out, flit_out_valid);
      end
    end
    vectors++;
    if (dut.age[2] !== 5'd5) begin
      miscompares++;
      $display("FAIL bp_age: got %0d want 5", dut.age[2]);
    end
    flit_out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      vectors++;
      if (flit_out !== 32'hB0 + k || flit_out_valid !== 1'b1 || grant_id !== 2'd2) begin
        miscompares++;
        $display("FAIL bp_resume_%0d: got flit=%h valid=%0b want %h/1", k, flit_out, flit_out_valid, 32'hB0 + k);
      end
      drive(2, 1, 1, 32'hB0 + k + 1);
    end
    req_valid = '0; cycle();
  endtask

`ifdef TX_PACKET_ARBITER_STATS_EN
  task automatic test_stats();
    req_valid = '0; flit_out_ready = 1'b1;
    pulse_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 1, 32'h100 + k); cycle();
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      drive(2, 1, k == 2, 32'h200 + k); cycle();
    end
    req_valid = '0; cycle();
    vectors++;
    if (stat_grants !== {32'd0, 32'd3, 32'd10, 32'd0}) begin
      miscompares++;
      $display("FAIL stats_grants: got %h want 0/3/10/0", stat_grants);
    end
  endtask
`endif

  task automatic test_random();
    int left [NUM_REQ];
    int bad_ready, bad_valid, bad_data;
    for (int i = 0; i < NUM_REQ; i++) left[i] = 0;
    req_valid = '0; flit_out_ready = 1'b1;
    pulse_reset();
    for (int c = 0; c < 1500; c++) begin
      flit_out_ready = ($urandom_range(3) != 0);
      cycle();
      vectors++;
      if (obs_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL rand_ready cyc %0d: got %b want %b", c, obs_ready, exp_ready);
      end
      vectors++;
      if (flit_out_valid !== m_ovalid) begin
        miscompares++;
        $display("FAIL rand_valid cyc %0d: got %0b want %0b", c, flit_out_valid, m_ovalid);
      end
      if (m_ovalid) begin
        vectors++;
        if (grant_id !== 2'(m_ogrant) || flit_out !== m_oflit) begin
          miscompares++;
          $display("FAIL rand_data cyc %0d: got grant=%0d flit=%h want %0d/%h", c, grant_id, flit_out, m_ogrant, m_oflit);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          left[i]--;
          if (left[i] == 0 || $urandom_range(3) == 0) req_valid[i] = 1'b0;
          else drive(i, 1, left[i] == 1, $urandom);
        end else if (!req_valid[i]) begin
          if (left[i] > 0) begin
            if ($urandom_range(1) == 1) drive(i, 1, left[i] == 1, $urandom);
          end else if ($urandom_range(2) == 0) begin
            left[i] = $urandom_range(4, 1);
            drive(i, 1, left[i] == 1, $urandom);
          end
        end
      end
    end
`ifdef TX_PACKET_ARBITER_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      vectors++;
      if (stat_grants[i*32 +: 32] !== 32'(m_grants[i])) begin
        miscompares++;
        $display("FAIL rand_stat_grants[%0d]: got %0d want %0d", i, stat_grants[i*32 +: 32], m_grants[i]);
      end
    end
    vectors++;
    if (stat_starve_promotions !== 32'(m_promos)) begin
      miscompares++;
      $display("FAIL rand_stat_promos: got %0d want %0d", stat_starve_promotions, m_promos);
    end
`endif
    bad_ready = 0; bad_valid = 0; bad_data = 0;
    req_valid = '0; flit_out_ready = 1'b1; cycle();
  endtask

  initial begin
    req_flit = '0; req_valid = '0; req_last = '0; flit_out_ready = 1'b1; rst = 1'b1;
    m_reset();
    test_reset();
    test_priority();
    test_lock();
    test_starvation();
    test_backpressure();
`ifdef TX_PACKET_ARBITER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
